// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone cycle/burst type constants and slave state type
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        BURST  = 2'd2
    } state_t;

    function automatic logic cti_reserved(input logic [2:0] cti);
        return !(cti == CTI_CLASSIC || cti == CTI_CONST ||
                 cti == CTI_INCR    || cti == CTI_END);
    endfunction

endpackage

// File: rtl/wb_regbank_if.sv
// rtl/wb_regbank_if.sv - Wishbone B4 slave-side bus bundle with master/slave views
interface wb_regbank_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic [2:0]  cti_i;
    logic [1:0]  bte_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, cti_i, bte_i,
        input  dat_o, ack_o, err_o, rty_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, cti_i, bte_i,
        output dat_o, ack_o, err_o, rty_o
    );
endinterface

// File: rtl/wb_burst_addr.sv
// rtl/wb_burst_addr.sv - burst word-index counter with load, step and bte wrap
module wb_burst_addr
    import wb_pkg::*;
#(
    parameter int ADR_BITS = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                step,
    input  logic [ADR_BITS-1:0] start,
    input  logic [1:0]          bte,
    output logic [ADR_BITS-1:0] idx
);
    logic [ADR_BITS-1:0] base;
    logic [ADR_BITS-1:0] inc;
    logic [ADR_BITS-1:0] mask;
    logic [ADR_BITS-1:0] nxt;

    // mask selects the index bits that count; the rest stay fixed on wrap
    always_comb begin
        base = load ? start : idx;
        inc  = base + ADR_BITS'(1);
        case (bte)
            BTE_WRAP4:  mask = ADR_BITS'(3);
            BTE_WRAP8:  mask = ADR_BITS'(7);
            BTE_WRAP16: mask = ADR_BITS'(15);
            default:    mask = '1;
        endcase
        nxt = (base & ~mask) | (inc & mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (load || step) begin
            idx <= step ? nxt : base;
        end
    end
endmodule

// File: rtl/wb_regbank.sv
// rtl/wb_regbank.sv - Wishbone B4 register-file slave with control/status words and bursts
module wb_regbank
    import wb_pkg::*;
#(
    parameter int                 N_RW       = 8,
    parameter int                 N_RO       = 8,
    parameter int                 ADR_BITS   = 10,
    parameter logic [N_RW*32-1:0] RST_VAL    = '0,
    parameter logic [N_RW*32-1:0] PULSE_MASK = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    wb_regbank_if.slave        wb,
    output logic [N_RW*32-1:0] ctrl_o,
    output logic [N_RW-1:0]    ctrl_wr_o,
    input  logic [N_RO*32-1:0] stat_i
);
    state_t              state;
    state_t              state_nxt;
    logic [ADR_BITS-1:0] idx;
    logic [ADR_BITS-1:0] cnt;
    logic                accept;
    logic                in_rw;
    logic                in_ro;
    logic                beat_err;
    logic                do_wr;
    logic                cnt_load;
    logic                cnt_step;
    logic [31:0]         rd_data;
    logic [31:0]         dat_q;
    logic                ack_q;
    logic                err_q;
    logic [N_RW*32-1:0]  ctrl_nxt;
    logic [N_RW-1:0]     wr_vec;
    logic                unused_adr;

    assign unused_adr = ^{wb.adr_i[31:ADR_BITS+2], wb.adr_i[1:0]};

    wb_burst_addr #(.ADR_BITS(ADR_BITS)) u_burst_addr (
        .clk   (clk_i),
        .reset (reset_i),
        .load  (cnt_load),
        .step  (cnt_step),
        .start (idx),
        .bte   (wb.bte_i),
        .idx   (cnt)
    );

    // Beat decode: index source, error classification, read mux and write merge
    always_comb begin
        idx      = (state == BURST) ? cnt : wb.adr_i[ADR_BITS+1:2];
        in_rw    = int'(idx) < N_RW;
        in_ro    = !in_rw && (int'(idx) < N_RW + N_RO);
        accept   = wb.cyc_i && wb.stb_i && (state != SINGLE);
        beat_err = cti_reserved(wb.cti_i) || !(in_rw || (in_ro && !wb.we_i));
        do_wr    = accept && !beat_err && wb.we_i && in_rw;
        rd_data  = '0;
        wr_vec   = '0;
        ctrl_nxt = ctrl_o & ~PULSE_MASK;
        for (int k = 0; k < N_RW; k++) begin
            if (int'(idx) == k) begin
                rd_data   = ctrl_o[k*32 +: 32];
                wr_vec[k] = do_wr;
                for (int b = 0; b < 4; b++) begin
                    if (do_wr && wb.sel_i[b]) begin
                        ctrl_nxt[k*32 + b*8 +: 8] = wb.dat_i[b*8 +: 8];
                    end
                end
            end
        end
        for (int k = 0; k < N_RO; k++) begin
            if (int'(idx) == N_RW + k) begin
                rd_data = stat_i[k*32 +: 32];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_step  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (wb.cti_i == CTI_CONST || wb.cti_i == CTI_INCR) begin
                        state_nxt = BURST;
                        cnt_load  = 1'b1;
                        cnt_step  = (wb.cti_i == CTI_INCR);
                    end else if (!cti_reserved(wb.cti_i)) begin
                        state_nxt = SINGLE;
                    end
                end
            end
            SINGLE: state_nxt = IDLE;
            BURST: begin
                if (!wb.cyc_i) begin
                    state_nxt = IDLE;
                end else if (accept) begin
                    cnt_step = (wb.cti_i == CTI_INCR);
                    if (wb.cti_i == CTI_END || cti_reserved(wb.cti_i)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= IDLE;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            ctrl_o    <= RST_VAL;
            ctrl_wr_o <= '0;
        end else begin
            state     <= state_nxt;
            ack_q     <= accept && !beat_err;
            err_q     <= accept && beat_err;
            if (accept) begin
                dat_q <= (wb.we_i || beat_err) ? '0 : rd_data;
            end
            ctrl_o    <= ctrl_nxt;
            ctrl_wr_o <= wr_vec;
        end
    end

    assign wb.dat_o = dat_q;
    assign wb.ack_o = ack_q;
    assign wb.err_o = err_q;
    assign wb.rty_o = 1'b0;
endmodule

// File: tb/tb_wb_regbank.sv
// tb/tb_wb_regbank.sv - self-checking bench for wb_regbank
module tb_wb_regbank;
    localparam logic [255:0] RV = 256'hFFF;
    localparam logic [255:0] PM = 256'h1 << 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] ctrl;
    logic [7:0]   ctrl_wr;
    logic [255:0] stat;
    logic [31:0]  m_ctrl [8];
    int           errors = 0;
    int           checks = 0;

    wb_regbank_if bus ();

    wb_regbank #(
        .N_RW(8), .N_RO(8), .ADR_BITS(10), .RST_VAL(RV), .PULSE_MASK(PM)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .wb        (bus.slave),
        .ctrl_o    (ctrl),
        .ctrl_wr_o (ctrl_wr),
        .stat_i    (stat)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [2:0]  cti;
        bit          ack;
        bit          err;
        logic [31:0] rdat;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, predict from the register-file model, compare after posedge
    task automatic cycle(input bit r, input bit c, input bit s, input bit w,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl,
                         input logic [2:0] ct, input logic [1:0] bt, input bit beat,
                         input int idx, input string tag,
                         output logic o_ack, output logic o_err, output logic [31:0] o_dat);
        bit          e_err;
        bit          e_wr;
        logic [31:0] e_dat;
        logic [7:0]  e_wrv;
        @(negedge clk);
        reset = r; bus.cyc_i = c; bus.stb_i = s; bus.we_i = w; bus.adr_i = a;
        bus.dat_i = d; bus.sel_i = sl; bus.cti_i = ct; bus.bte_i = bt;
        e_err = (ct >= 3'd3 && ct <= 3'd6) || idx >= 16 || (w && idx >= 8);
        e_dat = '0;
        if (!w && !e_err) e_dat = (idx < 8) ? m_ctrl[idx] : stat[(idx-8)*32 +: 32];
        e_wr  = !r && beat && !e_err && w && idx < 8;
        @(posedge clk);
        e_wrv = '0;
        if (r) begin
            for (int k = 0; k < 8; k++) m_ctrl[k] = RV[k*32 +: 32];
        end else begin
            for (int k = 0; k < 8; k++) m_ctrl[k] = m_ctrl[k] & ~PM[k*32 +: 32];
            if (e_wr) begin
                for (int b = 0; b < 4; b++) if (sl[b]) m_ctrl[idx][b*8 +: 8] = d[b*8 +: 8];
                e_wrv[idx] = 1'b1;
            end
        end
        #1;
        o_ack = bus.ack_o; o_err = bus.err_o; o_dat = bus.dat_o;
        chk({tag, " ack"}, 32'(bus.ack_o), 32'(!r && beat && !e_err));
        chk({tag, " err"}, 32'(bus.err_o), 32'(!r && beat && e_err));
        if (r || (beat && ((!w && !e_err) || idx >= 16))) chk({tag, " dat"}, bus.dat_o, r ? 32'h0 : e_dat);
        for (int k = 0; k < 8; k++) chk($sformatf("%s ctrl%0d", tag, k), ctrl[k*32 +: 32], m_ctrl[k]);
        chk({tag, " ctrl_wr"}, 32'(ctrl_wr), 32'(e_wrv));
        chk({tag, " rty"}, 32'(bus.rty_o), 32'h0);
    endtask

    task automatic idle(input string tag);
        logic x1, x2; logic [31:0] x3;
        cycle(0, 0, 0, 0, '0, '0, '0, 3'b000, 2'b00, 0, 0, {tag, " idle"}, x1, x2, x3);
    endtask

    task automatic classic(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] sl, input logic [2:0] ct, input string tag,
                           output logic o_ack, output logic o_err, output logic [31:0] o_dat);
        cycle(0, 1, 1, w, a, d, sl, ct, 2'b00, 1, int'(a[11:2]), tag, o_ack, o_err, o_dat);
        idle(tag);
    endtask

    // Expected beat index is wrap arithmetic on the start index, not a replica counter
    task automatic burst(input bit w, input int start, input int n, input logic [1:0] bt,
                         input bit incr, input int wait_at, input int nwait, input int bad_at,
                         input string tag);
        int mask, idx;
        logic [2:0] ct;
        logic x1, x2; logic [31:0] x3;
        mask = (bt == 2'b00) ? 1023 : (2 << bt) - 1;
        for (int b = 0; b < n; b++) begin
            if (b == wait_at) begin
                for (int i = 0; i < nwait; i++)
                    cycle(0, 1, 0, w, $urandom, $urandom, 4'hF, 3'b010, bt, 0, 0,
                          $sformatf("%s wait%0d", tag, i), x1, x2, x3);
            end
            idx = incr ? ((start & ~mask) | ((start + b) & mask)) : start;
            ct  = (b == n-1) ? 3'b111 : (incr ? 3'b010 : 3'b001);
            if (b == bad_at) ct = 3'b100;
            cycle(0, 1, 1, w, (b == 0) ? (32'(start) << 2) : $urandom, $urandom, 4'($urandom),
                  ct, bt, 1, idx, $sformatf("%s beat%0d", tag, b), x1, x2, x3);
            if (b == bad_at) break;
        end
        idle(tag);
    endtask

    initial begin
        logic        a_ack, a_err;
        logic [31:0] a_dat;
        logic [31:0] a;
        logic [2:0]  ct;
        int          n;

        reset = 1'b1;
        bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; bus.adr_i = '0;
        bus.dat_i = '0; bus.sel_i = '0; bus.cti_i = '0; bus.bte_i = '0;
        for (int k = 0; k < 8; k++) begin
            stat[k*32 +: 32] = 32'hA5A5_0000 | 32'(k);
            m_ctrl[k] = RV[k*32 +: 32];
        end

        tbl[0]  = '{1, 32'h004,  32'hAABBCCDD, 4'b0101, 3'b000, 1, 0, 32'h0};
        tbl[1]  = '{0, 32'h004,  32'h0,        4'b1111, 3'b000, 1, 0, 32'h00BB00DD};
        tbl[2]  = '{0, 32'h000,  32'h0,        4'b1111, 3'b000, 1, 0, 32'h00000FFF};
        tbl[3]  = '{1, 32'h020,  32'h11111111, 4'b1111, 3'b000, 0, 1, 32'h0};
        tbl[4]  = '{0, 32'h050,  32'h0,        4'b1111, 3'b000, 0, 1, 32'h0};
        tbl[5]  = '{0, 32'h024,  32'h0,        4'b1111, 3'b000, 1, 0, 32'hA5A50001};
        tbl[6]  = '{1, 32'h000,  32'h12345678, 4'b1111, 3'b111, 1, 0, 32'h0};
        tbl[7]  = '{0, 32'h000,  32'h0,        4'b1111, 3'b000, 1, 0, 32'h12345678};
        tbl[8]  = '{1, 32'h01C,  32'hFFFFFFFF, 4'b0000, 3'b000, 1, 0, 32'h0};
        tbl[9]  = '{0, 32'h01C,  32'h0,        4'b1111, 3'b000, 1, 0, 32'h0};
        tbl[10] = '{0, 32'h004,  32'h0,        4'b1111, 3'b011, 0, 1, 32'h0};
        tbl[11] = '{1, 32'h010,  32'hDEADBEEF, 4'b1000, 3'b000, 1, 0, 32'h0};
        tbl[12] = '{0, 32'h010,  32'h0,        4'b1111, 3'b000, 1, 0, 32'hDE000000};
        tbl[13] = '{0, 32'hFFC,  32'h0,        4'b1111, 3'b000, 0, 1, 32'h0};
        tbl[14] = '{0, 32'h1004, 32'h0,        4'b1111, 3'b000, 1, 0, 32'h00BB00DD};
        tbl[15] = '{1, 32'h014,  32'h55555555, 4'b1111, 3'b000, 1, 0, 32'h0};
        tbl[16] = '{1, 32'h018,  32'h66666666, 4'b0011, 3'b000, 1, 0, 32'h0};
        tbl[17] = '{0, 32'h018,  32'h0,        4'b1111, 3'b000, 1, 0, 32'h00006666};

        cycle(1, 0, 0, 0, '0, '0, '0, 3'b000, 2'b00, 0, 0, "reset", a_ack, a_err, a_dat);
        cycle(1, 0, 0, 0, '0, '0, '0, 3'b000, 2'b00, 0, 0, "reset", a_ack, a_err, a_dat);
        chk("reset word0", ctrl[31:0], 32'h00000FFF);

        for (int i = 0; i < 18; i++) begin
            classic(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].cti,
                    $sformatf("tbl%0d", i), a_ack, a_err, a_dat);
            chk($sformatf("tbl%0d ack", i), 32'(a_ack), 32'(tbl[i].ack));
            chk($sformatf("tbl%0d err", i), 32'(a_err), 32'(tbl[i].err));
            if (!tbl[i].we) chk($sformatf("tbl%0d dat", i), a_dat, tbl[i].rdat);
        end

        burst(0, 6, 4, 2'b01, 1, -1, 0, -1, "wrap4 rd");

        // Classic cycle with stb held through the SINGLE state acks only once
        cycle(0, 1, 1, 0, 32'h0, '0, 4'hF, 3'b000, 2'b00, 1, 0, "hold beat", a_ack, a_err, a_dat);
        cycle(0, 1, 1, 0, 32'h0, '0, 4'hF, 3'b000, 2'b00, 0, 0, "hold single", a_ack, a_err, a_dat);
        idle("hold");

        classic(1, 32'h008, 32'h1, 4'b0001, 3'b000, "pulse", a_ack, a_err, a_dat);
        chk("pulse after", 32'(ctrl[64]), 32'h0);
        cycle(0, 1, 1, 1, 32'h008, 32'h1, 4'b0001, 3'b001, 2'b00, 1, 2, "pulse b0", a_ack, a_err, a_dat);
        chk("pulse b0 bit", 32'(ctrl[64]), 32'h1);
        cycle(0, 1, 1, 1, 32'h0, 32'h1, 4'b0001, 3'b111, 2'b00, 1, 2, "pulse b1", a_ack, a_err, a_dat);
        chk("pulse b1 bit", 32'(ctrl[64]), 32'h1);
        idle("pulse end");
        chk("pulse end bit", 32'(ctrl[64]), 32'h0);

        // Abandoned burst: waits, then cyc drops with a write presented
        cycle(0, 1, 1, 1, 32'h00C, 32'hCAFE0001, 4'hF, 3'b010, 2'b00, 1, 3, "abn b0", a_ack, a_err, a_dat);
        cycle(0, 1, 1, 1, 32'h0,   32'hCAFE0002, 4'hF, 3'b010, 2'b00, 1, 4, "abn b1", a_ack, a_err, a_dat);
        cycle(0, 1, 0, 1, 32'h0,   32'hCAFE0003, 4'hF, 3'b010, 2'b00, 0, 0, "abn w0", a_ack, a_err, a_dat);
        cycle(0, 1, 0, 1, 32'h0,   32'hCAFE0004, 4'hF, 3'b010, 2'b00, 0, 0, "abn w1", a_ack, a_err, a_dat);
        cycle(0, 0, 1, 1, 32'h0,   32'hCAFE0005, 4'hF, 3'b010, 2'b00, 0, 0, "abn drop", a_ack, a_err, a_dat);
        classic(0, 32'h000, '0, 4'hF, 3'b000, "abn after", a_ack, a_err, a_dat);
        chk("abn after dat", a_dat, 32'h12345678);

        burst(1, 3, 4, 2'b00, 1, 2, 2, -1, "wait resume");
        burst(0, 14, 4, 2'b10, 1, -1, 0, 1, "bad cti");

        // Reset in the middle of a burst aborts it
        cycle(0, 1, 1, 0, 32'h010, '0, 4'hF, 3'b010, 2'b00, 1, 4, "rst b0", a_ack, a_err, a_dat);
        cycle(1, 1, 1, 0, 32'h0,   '0, 4'hF, 3'b010, 2'b00, 0, 0, "rst mid", a_ack, a_err, a_dat);
        idle("rst after");

        for (int k = 0; k < 8; k++) stat[k*32 +: 32] = $urandom;
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom;
                a[11:2] = 10'($urandom_range(0, 19));
                ct = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 6))
                                                 : (($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000);
                classic(1'($urandom), a, $urandom, 4'($urandom), ct, "rnd classic", a_ack, a_err, a_dat);
            end else begin
                n = int'($urandom_range(2, 6));
                burst(1'($urandom), int'($urandom_range(0, 17)), n, 2'($urandom), 1'($urandom),
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n-1)) : -1,
                      int'($urandom_range(1, 3)),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, n-1)) : -1,
                      "rnd burst");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
